sbox_share_sequencer: RTL and testbench
=======================================

# sbox_share_sequencer

Control and data-movement stage for the first-order (d = 1) masked AES S-box pipeline. It accepts a two-share 128-bit state and feeds its 16 bytes into the masked S-box, one byte per cycle. It supplies fresh 8-bit randomness to the two gadget steps every cycle and collects the masked S-box outputs after the fixed pipeline latency. It writes each output byte back into a two-share result register. The block sits directly upstream and downstream of the S-box steps: it drives the step-1 input shares and the `r` inputs of both steps, and it consumes the step-2 output shares.

## Interface
Parameters:
- `PIPE_LAT`, default 2. Cycles from `sb_in*` being presented to the matching `sb_out*` being valid (step 1 + step 2, pipelined). Legal range 1..8.
- `LFSR_SEED`, default 32'hACE1_2468. Reset and fallback seed of the randomness LFSR. Must be non-zero.

Ports:
- `clk`  in  1  Single clock; all state is rising-edge.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `start`  in  1  Begin a 16-byte pass. Sampled only in IDLE.
- `state_in0`, `state_in1`  in  128 each  Input shares. Byte i = bits [8i+7:8i]. Sampled on an accepted `start`.
- `seed_load`  in  1  Load `seed` into the LFSR. Honoured only in IDLE.
- `seed`  in  32  New LFSR seed. Zero is replaced by `LFSR_SEED`.
- `sb_in0`, `sb_in1`  out  8 each  Shares to S-box step 1.
- `sb_r1`, `sb_r2`  out  8 each  Fresh randomness for step 1 and step 2.
- `sb_out0`, `sb_out1`  in  8 each  Shares from S-box step 2.
- `busy`  out  1  High in FEED and DRAIN.
- `done`  out  1  One-cycle pulse when the result is complete.
- `state_out0`, `state_out1`  out  128 each  Result shares. Held stable from `done` until the next accepted `start`.

## Operation
- FSM states: IDLE, FEED, DRAIN, DONE.
  - IDLE → FEED on `start`. Load both input shares into internal shift registers and clear the feed counter.
  - FEED: present byte `cnt` (0..15) of both shares on `sb_in0`/`sb_in1`, then increment `cnt`. After `cnt` = 15 is presented, go to DRAIN.
  - DRAIN: wait until all 16 captures have completed, then go to DONE.
  - DONE: pulse `done` for one cycle, then return to IDLE.
- Output capture uses a `PIPE_LAT`-deep valid shift register that carries a 4-bit byte index alongside the valid bit. When the tail entry is valid, capture `sb_out0`/`sb_out1` into byte `idx` of `state_out0`/`state_out1`.
- `state_out*` bytes not yet written in a pass keep their previous-pass values. A full pass overwrites all 16 bytes.
- `sb_in0`/`sb_in1` are driven to 0 whenever not in FEED, so no stale share is presented.
- Randomness comes from a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1. It advances every cycle, in every state, whenever `rst_n` is high.
  - `sb_r1` = lfsr[7:0], `sb_r2` = lfsr[15:8], both registered.
  - The two outputs must never share bits within the same cycle.
- Shares are never combined inside this block. No XOR of share 0 with share 1 anywhere.

## Timing
- Reset values: FSM = IDLE, `busy` = 0, `done` = 0, `sb_in*` = 0, `sb_r*` = 0, `state_out*` = 0, LFSR = `LFSR_SEED`, valid pipe cleared.
- Let cycle 0 be the cycle with `start` = 1 in IDLE.
  - Byte i is on `sb_in*` during cycle 1+i.
  - Byte i is captured at the end of cycle 1+i+`PIPE_LAT`.
  - `done` is high in cycle 17+`PIPE_LAT`, which is cycle 19 at the default.
  - `busy` is high for cycles 1..16+`PIPE_LAT`.
- `start` while busy or in DONE is ignored; it is not queued. `start` and `seed_load` in the same IDLE cycle: the seed takes effect first, and the pass starts.
- `seed_load` outside IDLE is ignored.
- Reset mid-pass aborts the pass. All outputs return to their reset values asynchronously, and no partial `done` is produced.
- The next pass can start in the cycle after `done`, so there is no dead cycle beyond DONE.

## Structure
- Shared package `sbox_seq_pkg`:
  - FSM state enum.
  - LFSR tap constant 32'h8020_0003.
  - `NUM_BYTES` = 16.
  - Byte-index type.
- Sub-module `sbox_rand_lfsr`: seeded Galois LFSR with load and zero-seed substitution. Reused by other masked stages.
- The valid/index delay line stays inline.

## Test plan
- Behavioural two-share S-box model with latency `PIPE_LAT`, `state_in0` = 0x0f0e…0100, `state_in1` = 0. Expected: `state_out0`^`state_out1` = 0x76ab…7c63 (S(0x00) = 0x63, S(0x01) = 0x7c, …, S(0x0f) = 0x76). `done` in cycle 19.
- Same plaintext but `state_in1` random and `state_in0` = plaintext^`state_in1`. Expected: the same unmasked result, and `sb_in0` never equals the plaintext byte for all 16 cycles.
- Assert `rst_n` low in cycle 9 of a pass. Expected: all outputs immediately return to reset values, and no `done`. A new `start` afterwards completes normally.
- `start` pulsed at cycles 0, 5, and 18. Expected: one pass only, and exactly one `done`. A `start` in cycle 20 is accepted.
- `seed_load` with `seed` = 0. Expected: the LFSR equals `LFSR_SEED` in the next cycle. Over 1000 cycles, `sb_r1` ≠ `sb_r2` in at least one cycle, and the LFSR is never zero.
- Sweep `PIPE_LAT` over 1 and 8. Expected: `done` in cycles 18 and 25, and all bytes land in the correct positions.

Source files
------------

// File: rtl/sbox_seq_pkg.sv
// Shared definitions for the masked S-box sequencer and its randomness source.
//   seq_state_e : sequencer FSM states
//   LFSR_TAPS   : Galois tap mask for x^32+x^22+x^2+x+1
//   NUM_BYTES   : bytes per AES state
//   byte_idx_t  : index of a byte within the state
//   lfsr_step   : one Galois LFSR advance
package sbox_seq_pkg;

   localparam int          NUM_BYTES = 16;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef logic [3:0] byte_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } seq_state_e;

   // Right-shifting Galois form: the bit falling out of bit 0 folds back in
   // through the tap mask.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

endpackage

// File: rtl/sbox_share_sequencer_if.sv
// Link between the sequencer and the two-step masked S-box.
//   sb_in0/sb_in1   : shares into step 1
//   sb_r1/sb_r2     : fresh randomness for step 1 / step 2
//   sb_out0/sb_out1 : shares out of step 2
// master = sequencer side, slave = S-box side.
interface sbox_share_sequencer_if;

   logic [7:0] sb_in0;
   logic [7:0] sb_in1;
   logic [7:0] sb_r1;
   logic [7:0] sb_r2;
   logic [7:0] sb_out0;
   logic [7:0] sb_out1;

   modport master (
      output sb_in0, sb_in1, sb_r1, sb_r2,
      input  sb_out0, sb_out1
   );

   modport slave (
      input  sb_in0, sb_in1, sb_r1, sb_r2,
      output sb_out0, sb_out1
   );

endinterface

// File: rtl/sbox_rand_lfsr.sv
// Seeded 32-bit Galois LFSR used as the randomness source of masked stages.
//   clk, rst_n : clock, async active-low reset (state returns to SEED)
//   load       : replace the state with seed this cycle instead of advancing
//   seed       : new seed; zero is swapped for SEED so the LFSR never locks up
//   rnd        : low OUT_W bits of the current state
// SEED must be non-zero.
module sbox_rand_lfsr
   import sbox_seq_pkg::*;
#(
   parameter logic [31:0] SEED  = 32'hACE1_2468,
   parameter int          OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [31:0]      seed,
   output logic [OUT_W-1:0] rnd
);

   logic [31:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr <= SEED;
      else if (load)
         lfsr <= (seed == 32'h0) ? SEED : seed;
      else
         lfsr <= lfsr_step(lfsr);
   end

   assign rnd = lfsr[OUT_W-1:0];

endmodule

// File: rtl/sbox_share_sequencer.sv
// Feeds a two-share 128-bit state into a first-order masked S-box one byte
// per cycle, supplies per-cycle randomness to both gadget steps and writes
// the returning shares back into a two-share result register.
//   clk, rst_n               : clock, async active-low reset
//   start                    : begin a 16-byte pass (IDLE only)
//   state_in0/state_in1      : input shares, sampled on an accepted start
//   seed_load/seed           : reseed the LFSR (IDLE only)
//   sb                       : S-box link (shares out, randomness out, shares in)
//   busy                     : high in FEED and DRAIN
//   done                     : one-cycle pulse when the result is complete
//   state_out0/state_out1    : result shares, stable from done to next start
// PIPE_LAT (1..8) is the S-box latency from sb_in to matching sb_out.
// Share 0 and share 1 travel on separate paths and are never combined here.
module sbox_share_sequencer
   import sbox_seq_pkg::*;
#(
   parameter int          PIPE_LAT  = 2,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [127:0]           state_in0,
   input  logic [127:0]           state_in1,
   input  logic                   seed_load,
   input  logic [31:0]            seed,
   sbox_share_sequencer_if.master sb,
   output logic                   busy,
   output logic                   done,
   output logic [127:0]           state_out0,
   output logic [127:0]           state_out1
);

   seq_state_e state, state_nxt;

   byte_idx_t    cnt;
   logic [127:0] sh0, sh1;

   // Delay line matching the S-box latency: valid bit plus the byte index
   // that will be on sb_out* when the entry reaches the tail.
   logic      [PIPE_LAT-1:0] vld_pipe;
   byte_idx_t [PIPE_LAT-1:0] idx_pipe;
   logic                     cap;
   byte_idx_t                cap_idx;

   logic        feed, accept, lfsr_load;
   logic [15:0] rnd;
   logic [7:0]  r1_q, r2_q;

   assign cap     = vld_pipe[PIPE_LAT-1];
   assign cap_idx = idx_pipe[PIPE_LAT-1];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_FEED;
         ST_FEED:  if (cnt == byte_idx_t'(NUM_BYTES - 1)) state_nxt = ST_DRAIN;
         // Leave once the last byte is being captured this cycle.
         ST_DRAIN: if (cap && cap_idx == byte_idx_t'(NUM_BYTES - 1)) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      feed      = 1'b0;
      accept    = 1'b0;
      lfsr_load = 1'b0;
      case (state)
         ST_IDLE: begin
            accept    = start;
            lfsr_load = seed_load;
         end
         ST_FEED: begin
            busy = 1'b1;
            feed = 1'b1;
         end
         ST_DRAIN: busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // ---------------- input shift registers / feed counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh0 <= '0;
         sh1 <= '0;
         cnt <= '0;
      end else if (accept) begin
         sh0 <= state_in0;
         sh1 <= state_in1;
         cnt <= '0;
      end else if (feed) begin
         sh0 <= sh0 >> 8;
         sh1 <= sh1 >> 8;
         cnt <= cnt + 4'd1;
      end
   end

   // Inputs are forced to zero outside FEED so no stale share leaks out.
   assign sb.sb_in0 = feed ? sh0[7:0] : 8'h00;
   assign sb.sb_in1 = feed ? sh1[7:0] : 8'h00;

   // ---------------- valid / index delay line ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         idx_pipe <= '0;
      end else begin
         vld_pipe[0] <= feed;
         idx_pipe[0] <= cnt;
         for (int k = 1; k < PIPE_LAT; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            idx_pipe[k] <= idx_pipe[k-1];
         end
      end
   end

   // ---------------- result capture ----------------
   // Bytes not yet rewritten keep the previous pass's value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_out0 <= '0;
         state_out1 <= '0;
      end else if (cap) begin
         state_out0[{cap_idx, 3'b000} +: 8] <= sb.sb_out0;
         state_out1[{cap_idx, 3'b000} +: 8] <= sb.sb_out1;
      end
   end

   // ---------------- randomness ----------------
   sbox_rand_lfsr #(
      .SEED  (LFSR_SEED),
      .OUT_W (16)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_load),
      .seed  (seed),
      .rnd   (rnd)
   );

   // Disjoint LFSR bytes so step 1 and step 2 never see shared bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_q <= '0;
         r2_q <= '0;
      end else begin
         r1_q <= rnd[7:0];
         r2_q <= rnd[15:8];
      end
   end

   assign sb.sb_r1 = r1_q;
   assign sb.sb_r2 = r2_q;

endmodule

// File: tb/tb_sbox_share_sequencer.sv
// Bench for sbox_share_sequencer: three instances (PIPE_LAT 1, 2, 8) share
// stimulus; each has a two-share S-box model and a cycle-level reference
// model derived from pass-relative cycle numbers.
module tb_sbox_share_sequencer;
   import sbox_seq_pkg::*;

   localparam logic [31:0]  SEED0 = 32'hACE1_2468;
   localparam int           NI    = 3;
   localparam int           DONE_LIT [NI] = '{18, 19, 25};
   localparam logic [127:0] PLAIN   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
   localparam logic [127:0] EXP_LIT = 128'h76abd7fe_2b670130_c56f6bf2_7b777c63;

   logic         clk = 0;
   logic         rst_n = 1;
   logic         start = 0;
   logic         seed_load = 0;
   logic [31:0]  seed = 0;
   logic [127:0] in0 = 0, in1 = 0;

   int n_vec = 0, n_err = 0;
   int gcyc = 0;
   bit chk_on = 0;
   bit chk_mask = 0;

   int           done_cnt [NI];
   int           done_at  [NI];
   logic [127:0] res      [NI];

   logic [NI-1:0]        busy_a, done_a;
   logic [NI-1:0][7:0]   in0_a, in1_a, r1_a, r2_a;
   logic [NI-1:0][127:0] so0_a, so1_a;

   logic [7:0] sbox_tab [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   always #5 clk = ~clk;
   always @(posedge clk) gcyc <= gcyc + 1;

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : gi
      localparam int PL = (g == 0) ? 1 : ((g == 1) ? 2 : 8);

      sbox_share_sequencer_if sif();
      logic         busy, done;
      logic [127:0] so0, so1;

      sbox_share_sequencer #(.PIPE_LAT(PL), .LFSR_SEED(SEED0)) dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .start      (start),
         .state_in0  (in0),
         .state_in1  (in1),
         .seed_load  (seed_load),
         .seed       (seed),
         .sb         (sif.master),
         .busy       (busy),
         .done       (done),
         .state_out0 (so0),
         .state_out1 (so1)
      );

      assign busy_a[g] = busy;
      assign done_a[g] = done;
      assign in0_a[g]  = sif.sb_in0;
      assign in1_a[g]  = sif.sb_in1;
      assign r1_a[g]   = sif.sb_r1;
      assign r2_a[g]   = sif.sb_r2;
      assign so0_a[g]  = so0;
      assign so1_a[g]  = so1;

      // Two-share S-box: output share 1 is the step-2 mask, share 0 the
      // masked S-box value; PL cycles from input to output.
      logic [7:0] d0 [PL];
      logic [7:0] d1 [PL];
      always @(posedge clk) begin
         d0[0] <= sbox_tab[sif.sb_in0 ^ sif.sb_in1] ^ sif.sb_r2;
         d1[0] <= sif.sb_r2;
         for (int k = 1; k < PL; k++) begin
            d0[k] <= d0[k-1];
            d1[k] <= d1[k-1];
         end
      end
      assign sif.sb_out0 = d0[PL-1];
      assign sif.sb_out1 = d1[PL-1];

      // Reference model: pass position k = cycles since accepted start.
      bit           act = 0, idle;
      int           t0 = 0, k, ci;
      logic [127:0] p0, p1, pp;
      logic [31:0]  m_lfsr = SEED0;
      logic [7:0]   m_r1 = 0, m_r2 = 0;
      logic [127:0] e0 = 0, e1 = 0;
      logic [7:0]   mask [16];
      bit           e_busy = 0, e_done = 0;
      logic [7:0]   e_in0 = 0, e_in1 = 0;

      initial forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            act = 0; m_lfsr = SEED0; m_r1 = 0; m_r2 = 0; e0 = 0; e1 = 0;
            e_busy = 0; e_done = 0; e_in0 = 0; e_in1 = 0;
         end else begin
            idle = !act;
            k = gcyc - t0;
            if (act) begin
               if (k >= 1 && k <= 16) mask[k-1] = m_r2;
               if (k >= 1 + PL && k <= 16 + PL) begin
                  ci = k - 1 - PL;
                  e0[8*ci +: 8] = sbox_tab[pp[8*ci +: 8]] ^ mask[ci];
                  e1[8*ci +: 8] = mask[ci];
               end
               if (k == 17 + PL) act = 0;
            end
            m_r1 = m_lfsr[7:0];
            m_r2 = m_lfsr[15:8];
            if (idle && seed_load) m_lfsr = (seed == 0) ? SEED0 : seed;
            else                   m_lfsr = {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
            if (idle && start) begin
               act = 1; t0 = gcyc; p0 = in0; p1 = in1; pp = in0 ^ in1;
            end
            k = gcyc + 1 - t0;
            e_busy = act && k >= 1 && k <= 16 + PL;
            e_done = act && k == 17 + PL;
            e_in0  = (act && k >= 1 && k <= 16) ? p0[8*(k-1) +: 8] : 8'h00;
            e_in1  = (act && k >= 1 && k <= 16) ? p1[8*(k-1) +: 8] : 8'h00;
         end
      end

      initial forever begin
         @(negedge clk);
         if (rst_n && chk_on) begin
            chk($sformatf("i%0d_ctl", g),
                {busy, done, sif.sb_in0, sif.sb_in1, sif.sb_r1, sif.sb_r2},
                {e_busy, e_done, e_in0, e_in1, m_r1, m_r2});
            chk($sformatf("i%0d_out0", g), so0, e0);
            chk($sformatf("i%0d_out1", g), so1, e1);
            if (chk_mask && act && (gcyc - t0) >= 1 && (gcyc - t0) <= 16)
               chk($sformatf("i%0d_leak", g), sif.sb_in0 == pp[8*(gcyc-t0-1) +: 8], 1'b0);
            if (done) begin
               done_cnt[g] = done_cnt[g] + 1;
               done_at[g]  = gcyc;
               res[g]      = so0 ^ so1;
            end
         end
      end
   end

   function automatic logic [127:0] rand_mask();
      logic [127:0] m;
      for (int b = 0; b < 16; b++) m[8*b +: 8] = 8'($urandom_range(1, 255));
      return m;
   endfunction

   // Caller is #1 after a posedge with the sequencer idle.
   task automatic run_pass(input logic [127:0] m, input string tag);
      int base [NI];
      int t;
      for (int g = 0; g < NI; g++) base[g] = done_cnt[g];
      in1 = m; in0 = PLAIN ^ m; start = 1; t = gcyc;
      @(posedge clk); #1; start = 0;
      repeat (30) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("%s_ndone%0d", tag, g), done_cnt[g] - base[g], 1);
         chk($sformatf("%s_lat%0d", tag, g), done_at[g] - t, DONE_LIT[g]);
         chk($sformatf("%s_res%0d", tag, g), res[g], EXP_LIT);
      end
   endtask

   initial begin
      int base [NI];
      int t, ndiff;
      for (int g = 0; g < NI; g++) begin done_cnt[g] = 0; done_at[g] = 0; res[g] = 0; end

      #1 rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("rst_ctl%0d", g), {busy_a[g], done_a[g], in0_a[g], in1_a[g], r1_a[g], r2_a[g]}, 0);
         chk($sformatf("rst_out%0d", g), {so0_a[g], so1_a[g]}, 0);
      end
      rst_n = 1; chk_on = 1;
      repeat (3) @(posedge clk);
      #1;

      // unmasked plaintext, then masked with random share 1
      run_pass(128'h0, "plain");
      chk_mask = 1;
      run_pass(rand_mask(), "masked");
      chk_mask = 0;

      // reset in cycle 9 of a pass
      for (int g = 0; g < NI; g++) base[g] = done_cnt[g];
      in1 = rand_mask(); in0 = PLAIN ^ in1; start = 1;
      @(posedge clk); #1; start = 0;
      repeat (8) @(posedge clk);
      #1; rst_n = 0; #1;
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("abort_ctl%0d", g), {busy_a[g], done_a[g], in0_a[g], in1_a[g], r1_a[g], r2_a[g]}, 0);
         chk($sformatf("abort_out%0d", g), {so0_a[g], so1_a[g]}, 0);
      end
      @(posedge clk); #1; rst_n = 1;
      repeat (30) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++)
         chk($sformatf("abort_nodone%0d", g), done_cnt[g] - base[g], 0);
      run_pass(rand_mask(), "after_abort");

      // start pulsed at cycles 0, 5, 18, then 20
      for (int g = 0; g < NI; g++) base[g] = done_cnt[g];
      in1 = 0; in0 = PLAIN;
      for (int c = 0; c <= 20; c++) begin
         if (c == 20)
            for (int g = 0; g < NI; g++)
               chk($sformatf("multi_c20_%0d", g), done_cnt[g] - base[g], (g < 2) ? 1 : 0);
         start = (c == 0 || c == 5 || c == 18 || c == 20);
         @(posedge clk); #1;
      end
      start = 0;
      repeat (30) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++)
         chk($sformatf("multi_end%0d", g), done_cnt[g] - base[g], (g < 2) ? 2 : 1);

      // zero seed falls back to the reset seed
      seed = 0; seed_load = 1;
      @(posedge clk); #1; seed_load = 0;
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++)
         chk($sformatf("seed0_%0d", g), {r2_a[g], r1_a[g]}, 16'h2468);
      ndiff = 0;
      for (int c = 0; c < 1000; c++) begin
         if (r1_a[0] != r2_a[0]) ndiff++;
         @(posedge clk); #1;
      end
      chk("r_distinct", ndiff > 0, 1'b1);

      // random traffic: starts, seeds and inputs in every state
      for (int c = 0; c < 600; c++) begin
         start     = ($urandom % 6) == 0;
         seed_load = ($urandom % 12) == 0;
         seed      = (($urandom % 3) == 0) ? 32'h0 : $urandom;
         in0       = {$urandom, $urandom, $urandom, $urandom};
         in1       = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
      end
      start = 0; seed_load = 0;
      repeat (30) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
